// File: rtl/flappy_defs.sv
// Shared definitions for the flappy game blocks: state bit indices, tilt codes, physics defaults.
package flappy_defs;

  localparam int ST_START = 0;
  localparam int ST_GAME  = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_END   = 3;

  typedef enum logic [1:0] {
    TiltUp    = 2'b00,
    TiltLevel = 2'b01,
    TiltDown  = 2'b10,
    TiltDive  = 2'b11
  } tilt_e;

  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BIRD_H   = 16;
  localparam int DEF_START_Y  = 232;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = -8;
  localparam int DEF_MAX_FALL = 10;
  localparam int DEF_Y_W      = 10;
  localparam int DEF_VEL_W    = 6;

  function automatic tilt_e tilt_of(input int vel, input int max_fall);
    if (vel < 0)              return TiltUp;
    else if (vel <= 2)        return TiltLevel;
    else if (vel < max_fall)  return TiltDown;
    else                      return TiltDive;
  endfunction

endpackage

// File: rtl/bird_integrator.sv
// Combinational per-frame step: velocity update with fall saturation, semi-implicit position add,
// and ceiling/floor clamp.
module bird_integrator
  import flappy_defs::*;
#(
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BIRD_H   = DEF_BIRD_H,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int MAX_FALL = DEF_MAX_FALL,
  parameter int Y_W      = DEF_Y_W,
  parameter int VEL_W    = DEF_VEL_W
) (
  input  logic [Y_W-1:0]          bird_y,
  input  logic signed [VEL_W-1:0] bird_vel,
  input  logic                    flap_now,
  output logic signed [VEL_W-1:0] vel_n,
  output logic [Y_W-1:0]          y_n_clamped,
  output logic                    hit_n
);

  localparam logic signed [VEL_W:0]   MaxFallW = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W:0]   GravityW = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W-1:0] FlapVelW = VEL_W'(FLAP_VEL);
  localparam logic signed [Y_W+1:0]   FloorW   = (Y_W+2)'(SCREEN_H - BIRD_H);

  logic signed [VEL_W:0]   vel_inc;
  logic signed [VEL_W-1:0] vel_raw;
  logic signed [Y_W+1:0]   y_sum;

  always_comb begin
    // One extra bit so +GRAVITY cannot wrap before saturation.
    vel_inc = $signed({bird_vel[VEL_W-1], bird_vel}) + GravityW;
    if (flap_now)                vel_raw = FlapVelW;
    else if (vel_inc >= MaxFallW) vel_raw = MaxFallW[VEL_W-1:0];
    else                         vel_raw = vel_inc[VEL_W-1:0];

    y_sum = $signed({2'b00, bird_y}) + $signed({{(Y_W+2-VEL_W){vel_raw[VEL_W-1]}}, vel_raw});

    if (y_sum[Y_W+1] || (y_sum == '0)) begin
      y_n_clamped = '0;
      vel_n       = '0;
      hit_n       = 1'b1;
    end else if (y_sum >= FloorW) begin
      y_n_clamped = FloorW[Y_W-1:0];
      vel_n       = '0;
      hit_n       = 1'b1;
    end else begin
      y_n_clamped = y_sum[Y_W-1:0];
      vel_n       = vel_raw;
      hit_n       = 1'b0;
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Bird vertical-motion engine: per-frame velocity/position integration driven by game_state.
// Optional macro BIRD_TILT_EN adds a registered sprite tilt derived from the stored velocity.
module bird_physics
  import flappy_defs::*;
#(
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BIRD_H   = DEF_BIRD_H,
  parameter int START_Y  = DEF_START_Y,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int MAX_FALL = DEF_MAX_FALL,
  parameter int Y_W      = DEF_Y_W,
  parameter int VEL_W    = DEF_VEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              game_state,
  input  logic                    flap,
  input  logic                    frame_tick,
  output logic [Y_W-1:0]          bird_y,
  output logic signed [VEL_W-1:0] bird_vel,
  output logic                    boundary_hit,
  output logic [1:0]              bird_tilt
);

  logic                    flap_pending_q;
  logic                    legal, in_start, in_game, step_en;
  logic signed [VEL_W-1:0] vel_n;
  logic [Y_W-1:0]          y_n;
  logic                    hit_n;

  // Zero or multi-hot states decode to nothing active, i.e. a freeze like PAUSE.
  assign legal    = $onehot(game_state);
  assign in_start = legal && game_state[ST_START];
  assign in_game  = legal && game_state[ST_GAME];
  assign step_en  = in_game && frame_tick;

  bird_integrator #(
    .SCREEN_H (SCREEN_H),
    .BIRD_H   (BIRD_H),
    .GRAVITY  (GRAVITY),
    .FLAP_VEL (FLAP_VEL),
    .MAX_FALL (MAX_FALL),
    .Y_W      (Y_W),
    .VEL_W    (VEL_W)
  ) u_integrator (
    .bird_y      (bird_y),
    .bird_vel    (bird_vel),
    .flap_now    (flap_pending_q || flap),
    .vel_n       (vel_n),
    .y_n_clamped (y_n),
    .hit_n       (hit_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bird_y         <= Y_W'(START_Y);
      bird_vel       <= '0;
      boundary_hit   <= 1'b0;
      flap_pending_q <= 1'b0;
    end else begin
      flap_pending_q <= in_game && !frame_tick && (flap_pending_q || flap);
      if (in_start) begin
        bird_y       <= Y_W'(START_Y);
        bird_vel     <= '0;
        boundary_hit <= 1'b0;
      end else if (step_en) begin
        bird_y       <= y_n;
        bird_vel     <= vel_n;
        boundary_hit <= boundary_hit || hit_n;
      end
    end
  end

`ifdef BIRD_TILT_EN
  always_ff @(posedge clk) begin
    if (rst || in_start) bird_tilt <= TiltLevel;
    else if (step_en)    bird_tilt <= tilt_of(int'(vel_n), MAX_FALL);
  end
`else
  assign bird_tilt = TiltLevel;
`endif

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics: stimulus pushes hand-derived expectations, monitor checks.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        game_state = 4'b0001;
  logic              flap = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        bird_y;
  logic signed [5:0] bird_vel;
  logic              boundary_hit;
  logic [1:0]        bird_tilt;

  localparam logic [3:0] S = 4'b0001, G = 4'b0010, P = 4'b0100, E = 4'b1000;

  typedef struct {
    string      name;
    int         y;
    int         vel;
    logic       hit;
    logic [1:0] tilt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  bird_physics dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .flap         (flap),
    .frame_tick   (frame_tick),
    .bird_y       (bird_y),
    .bird_vel     (bird_vel),
    .boundary_hit (boundary_hit),
    .bird_tilt    (bird_tilt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_tilt(input int v);
    if (v < 0)       return 2'b00;
    else if (v <= 2) return 2'b01;
    else if (v < 10) return 2'b10;
    else             return 2'b11;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input string nm, input logic [3:0] st, input logic f, input logic t,
                      input logic r, input int ey, input int ev, input logic eh,
                      input logic [1:0] et);
    exp_t e;
    @(negedge clk);
    game_state = st;
    flap       = f;
    frame_tick = t;
    rst        = r;
    e.name = nm;
    e.y    = ey;
    e.vel  = ev;
    e.hit  = eh;
`ifdef BIRD_TILT_EN
    e.tilt = et;
`else
    e.tilt = 2'b01;
`endif
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t              e;
    logic [9:0]        ey;
    logic signed [5:0] ev;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ey = e.y[9:0];
        ev = e.vel[5:0];
        n_vec++;
        if (bird_y !== ey || bird_vel !== ev || boundary_hit !== e.hit || bird_tilt !== e.tilt) begin
          n_miss++;
          $display("FAIL %s: got y=%0d vel=%0d hit=%b tilt=%b, want y=%0d vel=%0d hit=%b tilt=%b",
                   e.name, bird_y, bird_vel, boundary_hit, bird_tilt, ey, ev, e.hit, e.tilt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int   y, v;
    logic h;

    step("reset", S, 0, 0, 1, 232, 0, 0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      step("start_tick", S, (i % 2 == 1), 1, 0, 232, 0, 0, 2'b01);
      step("start_idle", S, 0, 0, 0, 232, 0, 0, 2'b01);
    end

    step("game_t1",   G, 0, 1, 0, 233, 1, 0, 2'b01);
    step("game_hold", G, 0, 0, 0, 233, 1, 0, 2'b01);
    step("game_t2",   G, 0, 1, 0, 235, 2, 0, 2'b01);
    step("game_t3",   G, 0, 1, 0, 238, 3, 0, 2'b10);

    step("flap_pend", G, 1, 0, 0, 238, 3, 0, 2'b10);
    step("flap_wait", G, 0, 0, 0, 238, 3, 0, 2'b10);
    step("flap_tick", G, 0, 1, 0, 230, -8, 0, 2'b00);
    step("post_flap", G, 0, 1, 0, 223, -7, 0, 2'b00);

    step("to_start", S, 0, 0, 0, 232, 0, 0, 2'b01);
    y = 232; v = 0; h = 1'b0;
    while (!h) begin
      v = (v + 1 > 10) ? 10 : v + 1;
      y = y + v;
      if (y >= 464) begin
        y = 464; v = 0; h = 1'b1;
      end
      step("fall", G, 0, 1, 0, y, v, h, exp_tilt(v));
    end
    step("floor_again", G, 0, 1, 0, 464, 0, 1, 2'b01);
    step("end_hold",    E, 1, 1, 0, 464, 0, 1, 2'b01);
    step("end_hold2",   E, 0, 1, 0, 464, 0, 1, 2'b01);
    step("restart",     S, 0, 0, 0, 232, 0, 0, 2'b01);

    step("climb_flap", G, 1, 1, 0, 224, -8, 0, 2'b00);
    y = 224; v = -8;
    for (int i = 0; i < 6; i++) begin
      v = v + 1;
      y = y + v;
      step("coast", G, 0, 1, 0, y, v, 0, exp_tilt(v));
    end
    for (int i = 0; i < 24; i++) begin
      y = y - 8;
      step("climb", G, 1, 1, 0, y, -8, 0, 2'b00);
    end
    step("ceiling", G, 1, 1, 0, 0, 0, 1, 2'b01);

    for (int i = 0; i < 4; i++) step("pause", P, (i % 2 == 1), 1, 0, 0, 0, 1, 2'b01);
    step("illegal_zero",  4'b0000, 0, 1, 0, 0, 0, 1, 2'b01);
    step("illegal_multi", 4'b0011, 1, 1, 0, 0, 0, 1, 2'b01);
    step("game_sticky",   G, 0, 1, 0, 1, 1, 1, 2'b01);
    step("mid_reset",     G, 0, 1, 1, 232, 0, 0, 2'b01);

    step("flap_nogame_tick", G, 1, 0, 0, 232, 0, 0, 2'b01);
    step("pause_clears",     P, 0, 0, 0, 232, 0, 0, 2'b01);
    step("pending_gone",     G, 0, 1, 0, 233, 1, 0, 2'b01);
    step("multi_flap_a",     G, 1, 0, 0, 233, 1, 0, 2'b01);
    step("multi_flap_b",     G, 1, 0, 0, 233, 1, 0, 2'b01);
    step("multi_flap_tick",  G, 0, 1, 0, 225, -8, 0, 2'b00);

    step("idle", P, 0, 0, 0, 225, -8, 0, 2'b00);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
